// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control decoder.
// Owns the PC and drives a synchronous instruction ROM (1-cycle read latency).
// It presents one instruction per cycle through a 1-entry output slot backed by a 1-entry skid buffer.
// Taken branches redirect the PC through an internal target LUT.
// The HALT_CODE encoding stops fetch.
// Optional build macro: FETCH_PERF_EN adds the CycleCount/BubbleCount counters.
//
// Handshake: an instruction transfers to decode ("consume") in any cycle where
// InstrValid is high and Stall is low. While Stall is high, Instr/InstrValid/InstrPC
// hold. TakeBranch/TargetIdx mean something only in a consume cycle.
module fetch_unit #(
  parameter int AW = 10,
  parameter int IW = 9,
  parameter int TW = 5,
  parameter logic [IW-1:0] HALT_CODE = 9'h1FF
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          TakeBranch,
  input  logic [TW-1:0] TargetIdx,
  output logic          ImemRe,
  output logic [AW-1:0] ImemAddr,
  input  logic [IW-1:0] ImemData,
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  output logic [AW-1:0] InstrPC,
  output logic          Done,
  input  logic          LutWe,
  input  logic [TW-1:0] LutAddr,
  input  logic [AW-1:0] LutData,
`ifdef FETCH_PERF_EN
  output logic [15:0]   CycleCount,
  output logic [15:0]   BubbleCount,
`endif
  output logic [1:0]    dbg_state
);

  localparam int DEPTH = 1 << TW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] pc;
  logic [AW-1:0] addr_q;      // address of the most recent issue (the one returning now)
  logic          in_flight;   // ImemData carries a fresh return this cycle
  logic          slot_valid;  // output slot holds a stalled instruction
  logic [IW-1:0] slot_instr;
  logic [AW-1:0] slot_pc;
  logic          skid_valid;
  logic [IW-1:0] skid_instr;
  logic [AW-1:0] skid_pc;
  logic [AW-1:0] lut [DEPTH];

  logic consume;
  logic halt_now;
  logic branch_now;
  logic start_ok;
  logic issue;

  // A fresh ROM return with an empty slot goes straight to decode. Otherwise the slot register feeds decode.
  assign InstrValid = slot_valid | in_flight;
  assign Instr      = (!slot_valid && in_flight) ? ImemData : slot_instr;
  assign InstrPC    = (!slot_valid && in_flight) ? addr_q   : slot_pc;

  assign consume    = InstrValid & ~Stall;
  assign halt_now   = consume & (Instr == HALT_CODE);
  assign branch_now = consume & TakeBranch & ~halt_now;
  assign start_ok   = Start & (state != S_RUN);

  // Hold off issue whenever the slot/skid pair could not absorb another return.
  assign issue = (state == S_RUN) & ~halt_now & ~branch_now & ~skid_valid
               & ~(InstrValid & Stall & in_flight);

  assign ImemRe    = issue;
  assign ImemAddr  = issue ? pc : addr_q;
  assign Done      = (state == S_HALT);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: Start leaves IDLE/HALT, consuming the halt code ends RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start)    state_nxt = S_RUN;
      S_RUN:   if (halt_now) state_nxt = S_HALT;
      S_HALT:  if (Start)    state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC, issued address and in-flight tracking. A redirect or halt drops the in-flight return.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc        <= '0;
      addr_q    <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) addr_q <= pc;
      if (start_ok)        pc <= '0;
      else if (branch_now) pc <= lut[TargetIdx];
      else if (issue)      pc <= pc + 1'b1;
    end
  end

  // Output slot and skid buffer. These registers keep program order without loss or duplication under stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_valid <= 1'b0;
      slot_instr <= '0;
      slot_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (halt_now || branch_now || start_ok) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_valid) begin
      if (consume) begin
        if (skid_valid) begin
          slot_instr <= skid_instr;
          slot_pc    <= skid_pc;
          skid_valid <= 1'b0;
        end else if (in_flight) begin
          slot_instr <= ImemData;
          slot_pc    <= addr_q;
        end else begin
          slot_valid <= 1'b0;
        end
      end else if (in_flight) begin
        skid_instr <= ImemData;
        skid_pc    <= addr_q;
        skid_valid <= 1'b1;
      end
    end else if (in_flight && !consume) begin
      slot_instr <= ImemData;
      slot_pc    <= addr_q;
      slot_valid <= 1'b1;
    end
  end

  // Branch-target LUT. Writes land at the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating run-cycle and bubble counters. Both clear when Start is accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CycleCount  <= '0;
      BubbleCount <= '0;
    end else if (start_ok) begin
      CycleCount  <= '0;
      BubbleCount <= '0;
    end else if (state == S_RUN) begin
      if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
      if (!InstrValid && BubbleCount != 16'hFFFF) BubbleCount <= BubbleCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural synchronous ROM.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic       Stall;
  logic       TakeBranch;
  logic [4:0] TargetIdx;
  logic       ImemRe;
  logic [9:0] ImemAddr;
  logic [8:0] ImemData;
  logic [8:0] Instr;
  logic       InstrValid;
  logic [9:0] InstrPC;
  logic       Done;
  logic       LutWe;
  logic [4:0] LutAddr;
  logic [9:0] LutData;
  logic [1:0] dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0] CycleCount;
  logic [15:0] BubbleCount;
`endif

  logic [8:0] rom [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .TakeBranch(TakeBranch), .TargetIdx(TargetIdx),
    .ImemRe(ImemRe), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrPC(InstrPC), .Done(Done),
    .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
`ifdef FETCH_PERF_EN
    .CycleCount(CycleCount), .BubbleCount(BubbleCount),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROM, one-cycle read latency
  initial ImemData = '0;
  always @(posedge Clk) if (ImemRe) ImemData <= rom[ImemAddr];

  // Driver: advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge Clk);
    #2;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0; TakeBranch = 1'b0; TargetIdx = '0;
    LutWe = 1'b0; LutAddr = '0; LutData = '0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = 9'h010; rom[1] = 9'h020; rom[2] = 9'h030; rom[3] = 9'h1FF;
    rom[10'h040] = 9'h0AB; rom[10'h041] = 9'h1FF;
    #3;
    chk("rst_valid", InstrValid, 0);
    chk("rst_re", ImemRe, 0);
    chk("rst_done", Done, 0);
    chk("rst_addr", ImemAddr, 0);
    chk("rst_state", dbg_state, 0);
    next_cycle(); next_cycle(); Reset_n = 1'b1;

    // Straight-line program 010,020,030,HALT
    next_cycle(); Start = 1'b1; #1;
    chk("s1_idle_no_issue", ImemRe, 0);
    next_cycle(); Start = 1'b0; #1;
    chk("s1_state_run", dbg_state, 1);
    chk("s1_c1_valid", InstrValid, 0);
    chk("s1_c1_re", ImemRe, 1);
    chk("s1_c1_addr", ImemAddr, 0);
    next_cycle(); #1;
    chk("s1_c2_valid", InstrValid, 1);
    chk("s1_c2_instr", Instr, 9'h010);
    chk("s1_c2_pc", InstrPC, 0);
    next_cycle(); #1;
    chk("s1_c3_instr", Instr, 9'h020);
    next_cycle(); #1;
    chk("s1_c4_instr", Instr, 9'h030);
    next_cycle(); #1;
    chk("s1_c5_instr", Instr, 9'h1FF);
    chk("s1_c5_pc", InstrPC, 3);
    chk("s1_c5_re", ImemRe, 0);
    chk("s1_c5_addr", ImemAddr, 3);
    next_cycle(); #1;
    chk("s1_done", Done, 1);
    chk("s1_halt_valid", InstrValid, 0);
    chk("s1_halt_addr", ImemAddr, 3);
    chk("s1_state_halt", dbg_state, 2);

    // Stall held three cycles on 020
    next_cycle(); Start = 1'b1; #1;
    chk("s2_done_hold", Done, 1);
    next_cycle(); Start = 1'b0; #1;
    chk("s2_done_drop", Done, 0);
    chk("s2_c1_valid", InstrValid, 0);
    next_cycle(); #1;
    chk("s2_c2_instr", Instr, 9'h010);
    next_cycle(); Stall = 1'b1; #1;
    chk("s2_c3_instr", Instr, 9'h020);
    chk("s2_c3_pc", InstrPC, 1);
    chk("s2_c3_re", ImemRe, 0);
    next_cycle(); #1;
    chk("s2_c4_valid", InstrValid, 1);
    chk("s2_c4_instr", Instr, 9'h020);
    chk("s2_c4_pc", InstrPC, 1);
    chk("s2_c4_addr", ImemAddr, 2);
    next_cycle(); #1;
    chk("s2_c5_instr", Instr, 9'h020);
    chk("s2_c5_pc", InstrPC, 1);
    chk("s2_c5_re", ImemRe, 0);
    next_cycle(); Stall = 1'b0; #1;
    chk("s2_c6_instr", Instr, 9'h020);
    chk("s2_c6_pc", InstrPC, 1);
    next_cycle(); #1;
    chk("s2_c7_instr", Instr, 9'h030);
    chk("s2_c7_pc", InstrPC, 2);
    next_cycle(); #1;
    chk("s2_c8_instr", Instr, 9'h1FF);
    chk("s2_c8_pc", InstrPC, 3);
    next_cycle(); #1;
    chk("s2_done", Done, 1);

    // Taken branch through LUT[5]
    next_cycle(); LutWe = 1'b1; LutAddr = 5'd5; LutData = 10'h040;
    next_cycle(); LutWe = 1'b0; Start = 1'b1;
    next_cycle(); Start = 1'b0; TakeBranch = 1'b1; TargetIdx = 5'd5; #1;
    chk("s3_c1_valid", InstrValid, 0);
    next_cycle(); TakeBranch = 1'b0; #1;
    chk("s3_unconsumed_branch_ignored", InstrPC, 0);
    chk("s3_c2_instr", Instr, 9'h010);
    next_cycle(); #1;
    chk("s3_c3_instr", Instr, 9'h020);
    next_cycle(); TakeBranch = 1'b1; TargetIdx = 5'd5;
    LutWe = 1'b1; LutAddr = 5'd5; LutData = 10'h100; #1;
    chk("s3_c4_instr", Instr, 9'h030);
    chk("s3_c4_pc", InstrPC, 2);
    chk("s3_c4_re", ImemRe, 0);
    next_cycle(); TakeBranch = 1'b0; LutWe = 1'b0; #1;
    chk("s3_bubble", InstrValid, 0);
    chk("s3_target_re", ImemRe, 1);
    chk("s3_target_addr_old_lut", ImemAddr, 10'h040);
    next_cycle(); #1;
    chk("s3_target_valid", InstrValid, 1);
    chk("s3_target_pc", InstrPC, 10'h040);
    chk("s3_target_instr", Instr, 9'h0AB);
    next_cycle(); TakeBranch = 1'b1; TargetIdx = 5'd5; #1;
    chk("s3_halt_instr", Instr, 9'h1FF);
    chk("s3_halt_pc", InstrPC, 10'h041);
    next_cycle(); TakeBranch = 1'b0; #1;
    chk("s3_halt_over_branch", Done, 1);
    chk("s3_halt_valid", InstrValid, 0);

    // PC wrap 3FF -> 000
    rom[0] = 9'h012; rom[1] = 9'h1FF; rom[10'h3FF] = 9'h011;
    next_cycle(); LutWe = 1'b1; LutAddr = 5'd1; LutData = 10'h3FF;
    next_cycle(); LutWe = 1'b0; Start = 1'b1;
    next_cycle(); Start = 1'b0;
    next_cycle(); TakeBranch = 1'b1; TargetIdx = 5'd1; #1;
    chk("s4_c2_instr", Instr, 9'h012);
    next_cycle(); TakeBranch = 1'b0; #1;
    chk("s4_bubble", InstrValid, 0);
    chk("s4_target_addr", ImemAddr, 10'h3FF);
    next_cycle(); #1;
    chk("s4_pc_3ff", InstrPC, 10'h3FF);
    chk("s4_instr_3ff", Instr, 9'h011);
    next_cycle(); #1;
    chk("s4_wrap_valid", InstrValid, 1);
    chk("s4_pc_000", InstrPC, 10'h000);
    chk("s4_instr_000", Instr, 9'h012);
    next_cycle(); #1;
    chk("s4_pc_001", InstrPC, 10'h001);
    next_cycle(); #1;
    chk("s4_done", Done, 1);

    // Asynchronous reset with slot and skid both full
    next_cycle(); Start = 1'b1;
    next_cycle(); Start = 1'b0;
    next_cycle(); Stall = 1'b1; #1;
    chk("s5_c2_instr", Instr, 9'h012);
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    chk("s5_full_valid", InstrValid, 1);
    chk("s5_full_instr", Instr, 9'h012);
    chk("s5_full_no_issue", ImemRe, 0);
    #1 Reset_n = 1'b0;
    #1;
    chk("s5_rst_valid", InstrValid, 0);
    chk("s5_rst_instr", Instr, 0);
    chk("s5_rst_pc", InstrPC, 0);
    chk("s5_rst_re", ImemRe, 0);
    chk("s5_rst_addr", ImemAddr, 0);
    chk("s5_rst_done", Done, 0);
    chk("s5_rst_state", dbg_state, 0);
    Stall = 1'b0;
    #1 Reset_n = 1'b1;
    next_cycle(); #1;
    chk("s5_idle_re_a", ImemRe, 0);
    chk("s5_idle_valid", InstrValid, 0);
    next_cycle(); #1;
    chk("s5_idle_re_b", ImemRe, 0);
    chk("s5_idle_state", dbg_state, 0);
    next_cycle(); Start = 1'b1;
    next_cycle(); Start = 1'b0;
    next_cycle(); TakeBranch = 1'b1; TargetIdx = 5'd5; #1;
    chk("s5_c2_pc", InstrPC, 0);
    next_cycle(); TakeBranch = 1'b0; #1;
    chk("s5_lut_cleared_re", ImemRe, 1);
    chk("s5_lut_cleared_addr", ImemAddr, 0);
    next_cycle(); #1;
    chk("s5_target_pc", InstrPC, 0);
    chk("s5_target_instr", Instr, 9'h012);
    next_cycle(); #1;
    chk("s5_halt_instr", Instr, 9'h1FF);
    next_cycle(); #1;
    chk("s5_done", Done, 1);

`ifdef FETCH_PERF_EN
    // Perf counters: first program with one stall cycle
    rom[0] = 9'h010; rom[1] = 9'h020; rom[2] = 9'h030; rom[3] = 9'h1FF;
    next_cycle(); Start = 1'b1;
    next_cycle(); Start = 1'b0; #1;
    chk("p_cyc_clear", CycleCount, 0);
    chk("p_bub_clear", BubbleCount, 0);
    next_cycle();
    next_cycle(); Stall = 1'b1;
    next_cycle(); Stall = 1'b0;
    next_cycle();
    next_cycle(); #1;
    chk("p_halt_instr", Instr, 9'h1FF);
    next_cycle(); #1;
    chk("p_done", Done, 1);
    chk("p_cycle_count", CycleCount, 6);
    chk("p_bubble_count", BubbleCount, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the program counter and drives a synchronous instruction ROM with 1-cycle read latency.
- Presents one 9-bit instruction per cycle to decode through a valid/stall handshake, with a 1-entry skid buffer.
- Redirects the PC through an internal branch-target lookup table on taken branches, and stops on a halt encoding.

Parameters:
- AW, 10, PC / instruction-ROM address width.
- IW, 9, instruction width.
- TW, 5, branch-target LUT index width (2^TW entries of AW bits).
- HALT_CODE, 9'h1FF, instruction encoding that ends the program.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  pulse; begins execution at PC 0 from IDLE or HALT.
- Stall  in  1  decode cannot accept; holds Instr/InstrValid.
- TakeBranch  in  1  consumed instruction is a taken branch.
- TargetIdx  in  TW  LUT index of the branch target; sampled with TakeBranch.
- ImemRe  out  1  ROM read enable.
- ImemAddr  out  AW  ROM read address.
- ImemData  in  IW  ROM data, valid the cycle after ImemRe.
- Instr  out  IW  instruction to decode.
- InstrValid  out  1  Instr is valid.
- InstrPC  out  AW  address of Instr.
- Done  out  1  high in HALT.
- LutWe  in  1  LUT write enable.
- LutAddr  in  TW  LUT write index.
- LutData  in  AW  LUT write data.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - State IDLE.
  - PC, Instr, InstrPC, ImemAddr, all LUT entries = 0.
  - InstrValid, ImemRe, Done, in-flight flag, skid-valid = 0.
- Consume: InstrValid && !Stall.
- TakeBranch and TargetIdx are qualified only on consume; ignored otherwise.
- States:
  - IDLE: no issue. Start -> RUN, PC = 0.
  - RUN: issue when no flush/halt this cycle, skid empty, and not (InstrValid && Stall && in-flight).
    - Issue: ImemRe = 1, ImemAddr = PC, PC <= PC + 1.
    - PC wraps from 2^AW-1 to 0 silently.
  - HALT: Done = 1, no issue, InstrValid = 0. Start -> RUN at PC 0, Done drops the next cycle.
- Return path (cycle after issue):
  - If output slot is empty or consumed this cycle: data -> Instr, InstrValid = 1, InstrPC = issued address.
  - Otherwise data -> skid buffer.
  - On consume with skid valid: skid -> output, skid cleared.
  - Instructions are never dropped or duplicated under any Stall pattern.
  - Program order is preserved.
- Taken branch on consume:
  - PC <= LUT[TargetIdx].
  - In-flight return and skid are discarded.
  - InstrValid = 0 the next cycle (1 bubble).
  - Target is issued that cycle; target instruction is valid the cycle after.
- Halt: consume of Instr == HALT_CODE.
  - State -> HALT, in-flight and skid discarded, no further issue.
  - HALT takes priority over TakeBranch in the same cycle.
- Start while in RUN is ignored.
- LUT writes:
  - Accepted in any state; take effect the next cycle.
  - Same-cycle read of the entry being written returns the old value.
- Stall in IDLE/HALT has no effect.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs CycleCount[15:0] and BubbleCount[15:0], both reset to 0.
  - CycleCount increments every cycle in RUN.
  - BubbleCount increments in RUN when InstrValid = 0.
  - Both saturate at 16'hFFFF and clear on Start.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, Start, ROM[0..3] = 9'h010, 9'h020, 9'h030, HALT, Stall = 0.
  - Required: InstrValid first high 2 cycles after Start.
  - Required: Instr sequence 010, 020, 030, 1FF on consecutive cycles.
  - Required: Done = 1 the cycle after 1FF is consumed; ImemAddr never exceeds 3.
- Stall held 3 cycles while Instr = 020 is valid.
  - Required: Instr/InstrPC held at 020/1 throughout.
  - Required: after release 030 is presented next, then 1FF; no loss, no duplicate.
- LUT[5] = 10'h040 written, then TakeBranch = 1 with TargetIdx = 5 on consume of the PC-2 instruction.
  - Required: next cycle InstrValid = 0.
  - Required: following cycle InstrPC = 040, Instr = ROM[040]; PC-3 instruction never appears.
- PC preset via branch to 10'h3FF, ROM[3FF] = 9'h011, ROM[0] = 9'h012.
  - Required: InstrPC 3FF then 000 on consecutive cycles; no error.
- Reset_n pulsed low mid-RUN with skid full.
  - Required: all outputs 0 immediately (asynchronous); LUT cleared; state IDLE; no fetch until Start.
- FETCH_PERF_EN defined, run of the first scenario with 1 stall cycle inserted.
  - Required: BubbleCount = 1 at HALT entry; CycleCount equals cycles spent in RUN.
